screen_point_writer: RTL

// - Downstream of the float-to-screen mapping stage. Pairs the integer X and Y coordinates (0..360) from two mapper instances into one point.
// - Clips the point to the screen, computes the linear framebuffer address and queues it in a small FIFO.
// - Issues pixel writes to the framebuffer port. Also runs a full-screen clear sweep on request.

---
 rtl/screen_point_writer.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/screen_point_writer.sv
// ============================================================================
// Module      : screen_point_writer
// Description : Pairs X/Y screen coordinates, clips them, queues framebuffer
//               addresses in a show-ahead FIFO and issues pixel writes.
//               Also runs a full-screen clear sweep on request.
//               Optional macro SCREEN_CLIP_STATS_EN builds the clip counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module screen_point_writer #(
  parameter int SCREEN_W   = 361,
  parameter int SCREEN_H   = 361,
  parameter int ADDR_W     = 17,
  parameter int PIXEL_W    = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic               clk_in,
  input  logic               rst_in_n,
  input  logic               x_valid_in,
  input  logic [31:0]        x_in,
  input  logic               y_valid_in,
  input  logic [31:0]        y_in,
  input  logic [PIXEL_W-1:0] color_in,
  input  logic               clear_in,
  input  logic               fb_ready_in,
  output logic               fb_we_out,
  output logic [ADDR_W-1:0]  fb_addr_out,
  output logic [PIXEL_W-1:0] fb_data_out,
  output logic               busy_clear_out,
  output logic               clear_done_out,
  output logic               pair_err_out,
  output logic [15:0]        drop_count_out,
  output logic [15:0]        clip_count_out
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = ADDR_W + PIXEL_W;
  localparam int TOTAL   = SCREEN_W * SCREEN_H;
  localparam logic [PTR_W:0]  PTR_ONE  = 1;
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(TOTAL - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAW  = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [15:0]          x_hold_q, x_hold_d, y_hold_q, y_hold_d;
  logic                 x_hv_q, x_hv_d, y_hv_q, y_hv_d;
  logic                 pair_err_q, pair_err_d;
  logic                 stg_v_q, stg_v_d;
  logic [ADDR_W-1:0]    stg_addr_q, stg_addr_d;
  logic [PIXEL_W-1:0]   stg_color_q, stg_color_d;
  logic [PTR_W:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ENTRY_W-1:0]   mem_q [FIFO_DEPTH];
  logic [ADDR_W-1:0]    clr_cnt_q, clr_cnt_d;
  logic                 clr_pend_q, clr_pend_d;
  logic                 clr_done_q, clr_done_d;
  logic [15:0]          drop_cnt_q, drop_cnt_d;

  logic [15:0]          w_x, w_y;
  logic                 w_pair, w_in_range;
  logic [31:0]          w_addr_full;
  logic                 w_empty, w_full, w_xfer, w_pop, w_push, w_drop;
  logic [ENTRY_W-1:0]   w_head;
  logic                 unused_bits;

  // A coordinate arriving this cycle completes the pair with the held other axis.
  assign w_x         = x_valid_in ? x_in[15:0] : x_hold_q;
  assign w_y         = y_valid_in ? y_in[15:0] : y_hold_q;
  assign w_pair      = (x_valid_in | x_hv_q) & (y_valid_in | y_hv_q);
  assign w_in_range  = ({16'd0, w_x} < 32'(SCREEN_W)) && ({16'd0, w_y} < 32'(SCREEN_H));
  assign w_addr_full = ({16'd0, w_y} * 32'(SCREEN_W)) + {16'd0, w_x};
  assign unused_bits = ^{x_in[31:16], y_in[31:16], w_addr_full[31:ADDR_W]};

  assign w_empty = (wr_ptr_q == rd_ptr_q);
  assign w_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign w_head  = mem_q[rd_ptr_q[PTR_W-1:0]];
  assign w_xfer  = fb_we_out & fb_ready_in;
  assign w_pop   = (state_q == S_DRAW) & w_xfer;
  assign w_push  = stg_v_q & (~w_full | w_pop);
  assign w_drop  = stg_v_q & w_full & ~w_pop;

  always_comb begin
    x_hold_d    = x_hold_q;
    y_hold_d    = y_hold_q;
    x_hv_d      = x_hv_q | x_valid_in;
    y_hv_d      = y_hv_q | y_valid_in;
    pair_err_d  = (x_valid_in & x_hv_q) | (y_valid_in & y_hv_q);
    if (x_valid_in) x_hold_d = x_in[15:0];
    if (y_valid_in) y_hold_d = y_in[15:0];
    if (w_pair) begin
      x_hv_d = 1'b0;
      y_hv_d = 1'b0;
    end
    stg_v_d     = w_pair & w_in_range;
    stg_addr_d  = w_addr_full[ADDR_W-1:0];
    stg_color_d = color_in;
    wr_ptr_d    = w_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d    = w_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    drop_cnt_d  = (w_drop && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
  end

  always_comb begin
    fb_we_out      = 1'b0;
    fb_addr_out    = '0;
    fb_data_out    = '0;
    busy_clear_out = (state_q == S_CLEAR);
    if (state_q == S_CLEAR) begin
      fb_we_out   = 1'b1;
      fb_addr_out = clr_cnt_q;
    end else if (state_q == S_DRAW && !w_empty) begin
      fb_we_out   = 1'b1;
      fb_addr_out = w_head[ENTRY_W-1:PIXEL_W];
      fb_data_out = w_head[PIXEL_W-1:0];
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    clr_done_d = 1'b0;
    clr_pend_d = clr_pend_q | (clear_in & (state_q != S_CLEAR));
    case (state_q)
      S_IDLE: begin
        if (clr_pend_q || clear_in) state_d = S_CLEAR;
        else if (!w_empty)          state_d = S_DRAW;
      end
      S_DRAW: begin
        // Never abandon a presented write; switch only once it has landed.
        if ((clr_pend_q || clear_in) && (!fb_we_out || w_xfer)) state_d = S_CLEAR;
        else if (w_empty)                                        state_d = S_IDLE;
      end
      S_CLEAR: begin
        if (w_xfer) begin
          if (clr_cnt_q == CLR_LAST) begin
            clr_cnt_d  = '0;
            clr_done_d = 1'b1;
            clr_pend_d = 1'b0;
            state_d    = S_IDLE;
          end else begin
            clr_cnt_d = clr_cnt_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state_q     <= S_IDLE;
      x_hold_q    <= '0;
      y_hold_q    <= '0;
      x_hv_q      <= 1'b0;
      y_hv_q      <= 1'b0;
      pair_err_q  <= 1'b0;
      stg_v_q     <= 1'b0;
      stg_addr_q  <= '0;
      stg_color_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      clr_cnt_q   <= '0;
      clr_pend_q  <= 1'b0;
      clr_done_q  <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      x_hold_q    <= x_hold_d;
      y_hold_q    <= y_hold_d;
      x_hv_q      <= x_hv_d;
      y_hv_q      <= y_hv_d;
      pair_err_q  <= pair_err_d;
      stg_v_q     <= stg_v_d;
      stg_addr_q  <= stg_addr_d;
      stg_color_q <= stg_color_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      clr_cnt_q   <= clr_cnt_d;
      clr_pend_q  <= clr_pend_d;
      clr_done_q  <= clr_done_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= {stg_addr_q, stg_color_q};
  end

  assign clear_done_out = clr_done_q;
  assign pair_err_out   = pair_err_q;
  assign drop_count_out = drop_cnt_q;

`ifdef SCREEN_CLIP_STATS_EN
  logic [15:0] clip_cnt_q, clip_cnt_d;
  logic        w_clip;

  assign w_clip = w_pair & ~w_in_range;

  always_comb begin
    clip_cnt_d = (w_clip && clip_cnt_q != 16'hFFFF) ? clip_cnt_q + 16'd1 : clip_cnt_q;
  end

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) clip_cnt_q <= '0;
    else           clip_cnt_q <= clip_cnt_d;
  end

  assign clip_count_out = clip_cnt_q;
`else
  assign clip_count_out = '0;
`endif

endmodule

`default_nettype wire
